piso_shift_tx: RTL and testbench
================================

Name: piso_shift_tx

Overview:
- Parallel-in, serial-out transmitter; the launching end of the serial link whose capture end is the existing shift_reg block.
- Accepts WIDTH-bit words on a valid/ready handshake into a one-entry holding register.
- Serialises each word one bit per enabled clock, with frame and last-bit strobes.
- Supports back-to-back frames with no idle gap while the holding register is kept full.

Parameters:
WIDTH, 8, bits per serial frame (>=2)
MSB_FIRST, 1, 1 = transmit bit WIDTH-1 first; 0 = transmit bit 0 first

Ports:
clock  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
load_data  input  WIDTH  parallel word to transmit
load_valid  input  1  load_data is valid this cycle
load_ready  output  1  holding register empty; a word can be accepted
shift_en  input  1  bit-rate enable; the shifter advances only on edges where shift_en=1
ser_out  output  1  serial data, registered
ser_frame  output  1  high while a frame bit is driven on ser_out
ser_last  output  1  high while the final bit of a frame is driven
status  output  1  busy: ser_frame OR holding register occupied

Behaviour:
- Reset is synchronous and active-high. On an edge with reset=1:
  - hold_valid, state, bit counter, ser_out, ser_frame and ser_last are all cleared to 0.
  - status reads 0 and load_ready reads 1 after that edge.
  - Reset overrides every other input, including mid-frame; the partial frame is dropped and not resumed.
- load_ready = !hold_valid (combinational from a register). A transfer occurs on an edge where load_valid && load_ready. load_data is ignored when there is no transfer.
- States:
  - IDLE: ser_frame=0, ser_last=0, ser_out=0.
  - SHIFT: a frame is on the wire.
- IDLE -> SHIFT on the first edge where hold_valid=1 (independent of shift_en):
  - Holding register moves into the shift register; hold_valid clears.
  - bit_cnt=0; ser_out takes the first bit; ser_frame=1.
- Latency: a word accepted at edge N appears with its first bit valid after edge N+1 when starting from IDLE.
- A word accepted on the same edge the holding register is being emptied is impossible, because load_ready is low that cycle.
- In SHIFT, on an edge with shift_en=1:
  - If bit_cnt < WIDTH-1: shift, ser_out takes the next bit, bit_cnt increments.
  - If bit_cnt = WIDTH-1 (final bit being driven) and hold_valid=1: load the next word immediately, bit_cnt=0, ser_frame stays 1. This gives zero-gap back-to-back frames.
  - If bit_cnt = WIDTH-1 and hold_valid=0: go to IDLE; ser_frame and ser_out go to 0.
- In SHIFT with shift_en=0, all shifter state holds; the current bit stays on ser_out.
- ser_last=1 exactly while bit_cnt=WIDTH-1 in SHIFT.
- Bit order:
  - MSB_FIRST=1: sequence is data[WIDTH-1] down to data[0].
  - MSB_FIRST=0: sequence is data[0] up to data[WIDTH-1].
- bit_cnt width is clog2(WIDTH) and never wraps past WIDTH-1.
- shift_en is ignored in IDLE.
- A new word may be accepted into the holding register while a frame is shifting. It is held until the current frame's last bit retires.

Test Plan:
- Reset: drive reset=1 for 2 edges with arbitrary inputs -> ser_out=0, ser_frame=0, ser_last=0, status=0, load_ready=1.
- Single frame: shift_en=1 constantly; load 8'hA5 at edge N.
  - Bits on ser_out after edges N+1..N+8 are 1,0,1,0,0,1,0,1.
  - ser_frame high for 8 cycles; ser_last high only on the 8th bit.
  - status returns to 0 after edge N+9.
- Back-to-back: load 8'h3C, then 8'h C3 while the first frame is shifting -> ser_frame high for 16 consecutive cycles, sequence 00111100 11000011, ser_last pulses twice.
- Pacing: shift_en toggles 1,0,1,0 and 8'h81 is loaded -> each bit is held 2 cycles, ser_frame high for 16 cycles, and frame content is unchanged.
- Backpressure: with a frame shifting and a word already held, assert load_valid with 8'hFF -> load_ready=0 and the word is not captured. After the current frame, the held word is transmitted and then the line returns to IDLE.
- Reset mid-frame: assert reset after the 3rd bit of 8'hF0 -> after that edge all outputs are 0 and load_ready=1. A following load of 8'h55 transmits a clean 01010101.

Source files
------------

// File: rtl/piso_shift_tx.sv
`default_nettype none
// ============================================================================
// Module      : piso_shift_tx
// Description : Parallel-in serial-out transmitter. A one-entry holding
//               register takes words on a valid/ready handshake. The shifter
//               serialises each word one bit per enabled clock and drives
//               frame and last-bit strobes. Frames run back-to-back with no
//               gap while the holding register stays full.
// Revision    : 1.0 - initial release
// ============================================================================
module piso_shift_tx #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] load_data,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic             shift_en,
    output logic             ser_out,
    output logic             ser_frame,
    output logic             ser_last,
    output logic             status
);

    localparam int               CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] c_LAST   = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] c_PENULT = CNT_W'(WIDTH - 2);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } state_t;

    state_t           r_state;
    logic             r_hold_valid;
    logic [WIDTH-1:0] r_hold_data;
    logic [WIDTH-1:0] r_shreg;
    logic [CNT_W-1:0] r_bit_cnt;
    logic             r_ser_out;
    logic             r_ser_frame;
    logic             r_ser_last;

    logic             w_accept;
    logic             w_take;
    logic             w_first_bit;
    logic             w_next_bit;
    logic [WIDTH-1:0] w_shifted;

    // The shift register always presents the bit on the wire at the
    // outgoing end, so the next bit is the one adjacent to it.
    assign w_first_bit = MSB_FIRST ? r_hold_data[WIDTH-1] : r_hold_data[0];
    assign w_next_bit  = MSB_FIRST ? r_shreg[WIDTH-2]     : r_shreg[1];
    assign w_shifted   = MSB_FIRST ? {r_shreg[WIDTH-2:0], 1'b0}
                                   : {1'b0, r_shreg[WIDTH-1:1]};

    // Accept and take are mutually exclusive: one needs the holding
    // register empty, the other needs it full.
    assign w_accept = load_valid && !r_hold_valid;
    assign w_take   = r_hold_valid &&
                      ((r_state == S_IDLE) ||
                       ((r_state == S_SHIFT) && shift_en && (r_bit_cnt == c_LAST)));

    assign load_ready = !r_hold_valid;
    assign ser_out    = r_ser_out;
    assign ser_frame  = r_ser_frame;
    assign ser_last   = r_ser_last;
    assign status     = r_ser_frame || r_hold_valid;

    // Holding register: filled by the handshake, emptied when the shifter loads it.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_hold_valid <= 1'b0;
        end else if (w_accept) begin
            r_hold_valid <= 1'b1;
            r_hold_data  <= load_data;
        end else if (w_take) begin
            r_hold_valid <= 1'b0;
        end
    end

    // Shifter state machine with registered serial outputs and strobes.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_bit_cnt   <= '0;
            r_ser_out   <= 1'b0;
            r_ser_frame <= 1'b0;
            r_ser_last  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (r_hold_valid) begin
                        r_state     <= S_SHIFT;
                        r_shreg     <= r_hold_data;
                        r_bit_cnt   <= '0;
                        r_ser_out   <= w_first_bit;
                        r_ser_frame <= 1'b1;
                        r_ser_last  <= 1'b0;
                    end
                end
                S_SHIFT: begin
                    if (shift_en) begin
                        if (r_bit_cnt != c_LAST) begin
                            r_shreg    <= w_shifted;
                            r_ser_out  <= w_next_bit;
                            r_bit_cnt  <= r_bit_cnt + 1'b1;
                            r_ser_last <= (r_bit_cnt == c_PENULT);
                        end else if (r_hold_valid) begin
                            // Zero-gap chaining: next word starts right after the last bit.
                            r_shreg    <= r_hold_data;
                            r_ser_out  <= w_first_bit;
                            r_bit_cnt  <= '0;
                            r_ser_last <= 1'b0;
                        end else begin
                            r_state     <= S_IDLE;
                            r_bit_cnt   <= '0;
                            r_ser_out   <= 1'b0;
                            r_ser_frame <= 1'b0;
                            r_ser_last  <= 1'b0;
                        end
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_bit_cnt   <= '0;
                    r_ser_out   <= 1'b0;
                    r_ser_frame <= 1'b0;
                    r_ser_last  <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_piso_shift_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_piso_shift_tx
// Description : Scoreboard bench for piso_shift_tx. Every accepted word is
//               expanded into its expected serial bit stream and queued; a
//               monitor compares the wire against the queue each cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_piso_shift_tx;

    localparam int WIDTH     = 8;
    localparam bit MSB_FIRST = 1'b1;

    logic             clock;
    logic             reset;
    logic [WIDTH-1:0] load_data;
    logic             load_valid;
    logic             load_ready;
    logic             shift_en;
    logic             ser_out;
    logic             ser_frame;
    logic             ser_last;
    logic             status;

    typedef struct packed {
        logic b;
        logic last;
    } exp_t;

    exp_t q_exp[$];
    int   n_err    = 0;
    int   n_checks = 0;
    int   en_mode  = 0;   // 0: shift_en always 1, 1: toggling, 2: random

    piso_shift_tx #(
        .WIDTH     (WIDTH),
        .MSB_FIRST (MSB_FIRST)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .load_data  (load_data),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .shift_en   (shift_en),
        .ser_out    (ser_out),
        .ser_frame  (ser_frame),
        .ser_last   (ser_last),
        .status     (status)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at time %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard process: pushes on transfers at the rising edge, checks at the falling edge.
    initial begin : p_scoreboard
        exp_t e;
        int   idle_wait;
        bit   expect_cont;
        idle_wait   = 0;
        expect_cont = 0;
        forever begin
            @(posedge clock);
            if (reset) begin
                q_exp.delete();
            end else if (load_valid && load_ready) begin
                for (int i = 0; i < WIDTH; i++) begin
                    e.b    = MSB_FIRST ? load_data[WIDTH-1-i] : load_data[i];
                    e.last = (i == WIDTH - 1);
                    q_exp.push_back(e);
                end
            end
            @(negedge clock);
            if (reset) begin
                idle_wait   = 0;
                expect_cont = 0;
            end else begin
                check("status", 32'(status), 32'(q_exp.size() != 0));
                check("load_ready", 32'(load_ready),
                      ser_frame ? 32'(q_exp.size() <= WIDTH) : 32'(q_exp.size() == 0));
                if (expect_cont) begin
                    check("no_gap_frame", 32'(ser_frame), 32'd1);
                    expect_cont = 0;
                end
                if (ser_frame) begin
                    idle_wait = 0;
                    check("word_available", 32'(q_exp.size() != 0), 32'd1);
                    if (q_exp.size() != 0) begin
                        check("ser_out", 32'(ser_out), 32'(q_exp[0].b));
                        check("ser_last", 32'(ser_last), 32'(q_exp[0].last));
                        if (shift_en) begin
                            e = q_exp.pop_front();
                            if (e.last && q_exp.size() != 0) expect_cont = 1;
                        end
                    end
                end else begin
                    check("idle_outputs", 32'({ser_out, ser_last}), 32'd0);
                    if (q_exp.size() != 0) begin
                        idle_wait++;
                        check("start_latency", 32'(idle_wait <= 1), 32'd1);
                    end else begin
                        idle_wait = 0;
                    end
                end
            end
        end
    end

    // Bit-rate enable generator.
    initial begin : p_shift_en
        shift_en = 1'b1;
        forever begin
            @(posedge clock);
            #1;
            case (en_mode)
                0:       shift_en = 1'b1;
                1:       shift_en = ~shift_en;
                default: shift_en = ($urandom_range(0, 3) != 0);
            endcase
        end
    end

    task automatic send(input logic [WIDTH-1:0] d);
        int n;
        n          = 0;
        load_valid = 1'b1;
        load_data  = d;
        forever begin
            @(posedge clock);
            if (load_ready) break;
            n++;
            if (n > 200) begin
                $display("FAIL send_timeout: load_ready stuck low for word %0h", d);
                $fatal(1);
            end
        end
        #1;
        load_valid = 1'b0;
        load_data  = WIDTH'($urandom);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        do begin
            @(negedge clock);
            n++;
            if (n > 500) begin
                $display("FAIL idle_timeout: status stuck high");
                $fatal(1);
            end
        end while (status);
        @(posedge clock);
        #1;
    endtask

    initial begin : p_main
        reset      = 1'b1;
        load_valid = 1'(($urandom));
        load_data  = WIDTH'($urandom);
        repeat (2) @(posedge clock);
        #1;
        reset      = 1'b0;
        load_valid = 1'b0;
        repeat (2) @(posedge clock);
        #1;

        // Single frame
        send(8'hA5);
        wait_idle();

        // Back-to-back frames
        send(8'h3C);
        send(8'hC3);
        wait_idle();

        // Paced by a toggling enable
        en_mode = 1;
        send(8'h81);
        wait_idle();
        en_mode = 0;

        // Backpressure: offer 8'hFF while the holding register is full
        send(8'h12);
        send(8'h34);
        load_valid = 1'b1;
        load_data  = 8'hFF;
        repeat (3) @(posedge clock);
        #1;
        load_valid = 1'b0;
        wait_idle();

        // Reset in the middle of a frame, then a clean frame
        send(8'hF0);
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        send(8'h55);
        wait_idle();

        // Randomised traffic and enable pacing
        en_mode = 2;
        repeat (600) begin
            @(posedge clock);
            #1;
            load_valid = ($urandom_range(0, 2) == 0);
            load_data  = WIDTH'($urandom);
        end
        load_valid = 1'b0;
        wait_idle();
        en_mode = 0;
        repeat (3) @(posedge clock);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
